dlfloat_dot_seq: RTL and testbench
==================================

// Module: dlfloat_dot_seq
// PURPOSE
//  Sequencer for the DLFloat16 MAC (1s/6e bias 31/9m; 16'hFFFF = NaN).
//  Accepts a job of LEN operand pairs over valid/ready and clears the MAC accumulator before the job.
//  Feeds the pairs into the MAC and waits out the MAC pipeline, then returns the dot-product result over valid/ready.
//  Sits between the host-side operand loader and the dlfloat MAC datapath.
// PARAMETERS
//  LEN_W    8  width of job length / element counter (max LEN = 2**LEN_W-1)
//  MAC_LAT  2  cycles from mac_a/mac_b valid to accumulator updated (mult reg + acc reg)
//  CLR_CYC  2  cycles mac_clr_n held low to flush multiplier stage and accumulator
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      reset, asynchronous, active-low
//  start      in   1      begin job; sampled only in IDLE
//  abort      in   1      synchronous abandon of current job, any state
//  cfg_len    in   LEN_W  number of pairs in job; latched on start
//  busy       out  1      high in every state except IDLE
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      controller accepts pair
//  in_a       in   16     DLFloat operand A
//  in_b       in   16     DLFloat operand B
//  mac_a      out  16     registered operand A to MAC
//  mac_b      out  16     registered operand B to MAC
//  mac_clr_n  out  1      active-low accumulator clear to MAC
//  mac_acc    in   16     MAC accumulator output
//  res_valid  out  1      result valid
//  res_ready  in   1      result consumed
//  res_data   out  16     dot-product result
//  res_nan    out  1      some accepted operand was 16'hFFFF
//  res_count  out  LEN_W  pairs accepted in this job
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, except mac_clr_n = 1; counters 0.
//  mac_a/mac_b are 0 in every cycle without a handshake on the previous edge (zero product = bubble).
//  States:
//  - IDLE: in_ready = 0.
//    - start and cfg_len != 0: latch len, clear cnt and nan, go to CLEAR.
//    - start and cfg_len == 0: res_data <= 0, go to DONE.
//  - CLEAR: mac_clr_n = 0 for exactly CLR_CYC cycles, then go to FEED. in_ready = 0.
//  - FEED: in_ready = 1.
//    - On in_valid & in_ready: mac_a <= in_a, mac_b <= in_b, cnt++.
//    - If either operand == 16'hFFFF, set nan.
//    - Bubbles (in_valid = 0) are legal, unlimited length.
//    - The accept with cnt+1 == len moves to DRAIN; in_ready drops the next cycle.
//  - DRAIN: count MAC_LAT cycles, then at the next edge:
//    - res_data <= (nan ? 16'hFFFF : mac_acc), res_valid <= 1; go to DONE.
//    - res_valid is therefore first high MAC_LAT+1 edges after the final accept edge.
//  - DONE: res_valid = 1; res_data, res_nan and res_count held stable until res_ready.
//    - On res_valid & res_ready: res_valid <= 0, go to IDLE. The same-cycle start is ignored.
//  - start is ignored in every state except IDLE; no queuing.
//  - abort (priority over all else): next state IDLE.
//    - in_ready, res_valid <= 0; mac_a/mac_b <= 0; mac_clr_n <= 1.
//    - Job results are discarded.
//  - Async reset mid-job: same as abort, plus registers cleared immediately.
//  - cnt is LEN_W wide and never wraps: the job ends at len <= 2**LEN_W-1.
// TESTING
//  T1 len=1, (3E00,3E00) accepted -> res_valid 3 edges later, res_data=3E00, res_count=1, res_nan=0.
//  T2 len=3, three (3E00,3E00) pairs with 2-cycle bubble after first -> res_data=4100, mac_a=0 during bubble.
//  T3 len=2, pairs (3E00,FFFF),(3E00,3E00) -> res_data=FFFF, res_nan=1.
//  T4 start with cfg_len=0 -> DONE with res_data=0000, mac_clr_n stays 1, in_ready never high.
//  T5 res_ready low 5 cycles, start pulsed meanwhile -> outputs stable, start ignored; IDLE after consume.
//  T6 abort in FEED after 1 of 4 accepts, then new len=1 (4000,3E00) job -> res_data=4000 (clear verified).

Source files
------------

// File: rtl/dlfloat_dot_seq.sv
// dlfloat_dot_seq: job sequencer for the DLFloat16 MAC datapath.
// Takes a job of LEN operand pairs, flushes the MAC accumulator, streams the
// pairs into the MAC, waits out the MAC pipeline and returns the dot product.
// A NaN operand (16'hFFFF) anywhere in the job forces a NaN result.
module dlfloat_dot_seq #(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 2,
    parameter int CLR_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [LEN_W-1:0] i_cfg_len,
    output logic             o_busy,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [15:0]      i_in_a,
    input  logic [15:0]      i_in_b,
    output logic [15:0]      o_mac_a,
    output logic [15:0]      o_mac_b,
    output logic             o_mac_clr_n,
    input  logic [15:0]      i_mac_acc,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [15:0]      o_res_data,
    output logic             o_res_nan,
    output logic [LEN_W-1:0] o_res_count
);

    // Wait counter is shared by CLEAR and DRAIN; sized for the longer of the two.
    localparam int WC_W = $clog2(MAC_LAT + CLR_CYC + 1) + 1;
    localparam logic [WC_W-1:0] CLR_LAST = WC_W'(CLR_CYC - 1);
    localparam logic [WC_W-1:0] LAT_LAST = WC_W'(MAC_LAT);
    localparam logic [15:0]     NAN16    = 16'hFFFF;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic             r_nan;
    logic [WC_W-1:0]  r_wcnt;
    logic [15:0]      r_mac_a;
    logic [15:0]      r_mac_b;
    logic [15:0]      r_res_data;

    logic w_in_ready;
    logic w_accept;
    logic w_last;
    logic w_nan_in;

    // An abort in the same cycle as a handshake wins: the pair is not taken.
    assign w_accept = i_in_valid & w_in_ready & ~i_abort;
    assign w_last   = w_accept && (r_cnt == r_len - LEN_W'(1));
    assign w_nan_in = (i_in_a == NAN16) || (i_in_b == NAN16);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        w_next = r_state;
        if (i_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_start) w_next = (i_cfg_len != '0) ? S_CLEAR : S_DONE;
                S_CLEAR: if (r_wcnt == CLR_LAST) w_next = S_FEED;
                S_FEED:  if (w_last) w_next = S_DRAIN;
                S_DRAIN: if (r_wcnt == LAT_LAST) w_next = S_DONE;
                S_DONE:  if (i_res_ready) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // State-decoded control outputs
    always_comb begin
        o_busy      = (r_state != S_IDLE);
        w_in_ready  = (r_state == S_FEED);
        o_mac_clr_n = (r_state != S_CLEAR);
        o_res_valid = (r_state == S_DONE);
    end

    // Datapath: operand staging, job counters, result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mac_a    <= '0;
            r_mac_b    <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_nan      <= 1'b0;
            r_wcnt     <= '0;
            r_res_data <= '0;
        end else if (i_abort) begin
            r_mac_a    <= '0;
            r_mac_b    <= '0;
            r_cnt      <= '0;
            r_nan      <= 1'b0;
            r_wcnt     <= '0;
            r_res_data <= '0;
        end else begin
            // Non-handshake cycles push a zero product into the MAC
            r_mac_a <= w_accept ? i_in_a : '0;
            r_mac_b <= w_accept ? i_in_b : '0;
            if (r_state != w_next)
                r_wcnt <= '0;
            else if (r_state == S_CLEAR || r_state == S_DRAIN)
                r_wcnt <= r_wcnt + WC_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_len <= i_cfg_len;
                        r_cnt <= '0;
                        r_nan <= 1'b0;
                        if (i_cfg_len == '0) r_res_data <= '0;
                    end
                end
                S_FEED: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + LEN_W'(1);
                        if (w_nan_in) r_nan <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_wcnt == LAT_LAST) r_res_data <= r_nan ? NAN16 : i_mac_acc;
                end
                default: ;
            endcase
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_mac_a     = r_mac_a;
    assign o_mac_b     = r_mac_b;
    assign o_res_data  = r_res_data;
    assign o_res_nan   = r_nan;
    assign o_res_count = r_cnt;

endmodule

// File: tb/tb_dlfloat_dot_seq.sv
// tb_dlfloat_dot_seq: directed and randomized jobs against a real-valued
// dot-product reference, with a behavioural two-stage DLFloat MAC stub.
module tb_dlfloat_dot_seq;
    localparam int LEN_W   = 8;
    localparam int MAC_LAT = 2;
    localparam int CLR_CYC = 2;

    logic             clk;
    logic             rst_n;
    logic             start, abort, in_valid, res_ready;
    logic [LEN_W-1:0] cfg_len;
    logic [15:0]      in_a, in_b, mac_acc;
    logic             busy, in_ready, mac_clr_n, res_valid, res_nan;
    logic [15:0]      mac_a, mac_b, res_data;
    logic [LEN_W-1:0] res_count;

    int checks = 0;
    int errors = 0;

    // Operand alphabet: codes and their real values; index 5 is NaN
    logic [15:0] CODE [6] = '{16'h3C00, 16'h3E00, 16'h3F00, 16'h4000, 16'h4100, 16'hFFFF};
    real         VAL  [6] = '{0.5, 1.0, 1.5, 2.0, 3.0, 0.0};
    int ia [16];
    int ib [16];
    int bub[16];

    dlfloat_dot_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT), .CLR_CYC(CLR_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_cfg_len(cfg_len),
        .o_busy(busy), .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_a(in_a),
        .i_in_b(in_b), .o_mac_a(mac_a), .o_mac_b(mac_b), .o_mac_clr_n(mac_clr_n),
        .i_mac_acc(mac_acc), .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_data(res_data), .o_res_nan(res_nan), .o_res_count(res_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real dec(input logic [15:0] x);
        real m;
        int  e;
        if (x == 16'h0000 || x == 16'hFFFF) return 0.0;
        m = 1.0 + real'(x[8:0]) / 512.0;
        e = int'(x[14:9]) - 31;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[15] ? -m : m;
    endfunction

    // Exact for the positive values this bench produces (short mantissas)
    function automatic logic [15:0] enc(input real v);
        real m;
        int  e;
        int  f;
        if (v <= 0.0) return 16'h0000;
        m = v;
        e = 31;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        f = int'((m - 1.0) * 512.0);
        return {1'b0, e[5:0], f[8:0]};
    endfunction

    // MAC stub: multiplier register then accumulator register, both flushed by clear
    real m_prod, m_acc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prod <= 0.0;
            m_acc  <= 0.0;
        end else if (!mac_clr_n) begin
            m_prod <= 0.0;
            m_acc  <= 0.0;
        end else begin
            m_prod <= dec(mac_a) * dec(mac_b);
            m_acc  <= m_acc + m_prod;
        end
    end
    always_comb mac_acc = enc(m_acc);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a job and wait through CLEAR; leaves the bench at a negedge in FEED
    task automatic start_job(input int len);
        int n;
        int clr_cnt;
        start = 1'b1; cfg_len = LEN_W'(len);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        clr_cnt = 0; n = 0;
        while (!in_ready && n < 20) begin
            if (!mac_clr_n) clr_cnt++;
            @(negedge clk);
            n++;
        end
        chk("clear_cycles", clr_cnt, CLR_CYC);
    endtask

    task automatic feed_pair(input int i);
        for (int b = 0; b < bub[i]; b++) begin
            in_valid = 1'b0;
            @(negedge clk);
            chk("bubble_mac_a", mac_a, 0);
        end
        chk("in_ready_feed", in_ready, 1);
        in_valid = 1'b1; in_a = CODE[ia[i]]; in_b = CODE[ib[i]];
        @(negedge clk);
        in_valid = 1'b0;
        chk("mac_a_fed", mac_a, CODE[ia[i]]);
        chk("mac_b_fed", mac_b, CODE[ib[i]]);
    endtask

    task automatic run_job(input int len, input int hold, input bit poke_start);
        real         sum;
        bit          nan;
        int          n;
        logic [15:0] exp_data;
        logic [15:0] held;
        sum = 0.0; nan = 1'b0;
        for (int i = 0; i < len; i++) begin
            sum = sum + VAL[ia[i]] * VAL[ib[i]];
            if (ia[i] == 5 || ib[i] == 5) nan = 1'b1;
        end
        exp_data = nan ? 16'hFFFF : enc(sum);
        start_job(len);
        for (int i = 0; i < len; i++) feed_pair(i);
        chk("in_ready_drop", in_ready, 0);
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("res_latency", n, MAC_LAT + 1);
        chk("res_data", res_data, exp_data);
        chk("res_nan", res_nan, nan);
        chk("res_count", res_count, len);
        held = res_data;
        for (int h = 0; h < hold; h++) begin
            if (poke_start) begin start = 1'b1; cfg_len = 3; end
            @(negedge clk);
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, held);
            chk("hold_count", res_count, len);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0; start = 1'b0;
        chk("consume_idle", busy, 0);
        chk("consume_valid", res_valid, 0);
        @(negedge clk);
        chk("stay_idle", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_len = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_mac_a", mac_a, 0);
        chk("rst_mac_clr_n", mac_clr_n, 1);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_count", res_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: single pair 1.0*1.0
        ia[0] = 1; ib[0] = 1; bub[0] = 0;
        run_job(1, 0, 0);

        // T2: three 1.0*1.0 with a 2-cycle bubble after the first -> 3.0
        for (int i = 0; i < 3; i++) begin ia[i] = 1; ib[i] = 1; bub[i] = 0; end
        bub[1] = 2;
        run_job(3, 1, 0);

        // T3: NaN operand poisons the result
        ia[0] = 1; ib[0] = 5; bub[0] = 0;
        ia[1] = 1; ib[1] = 1; bub[1] = 0;
        run_job(2, 0, 0);

        // T4: zero-length job goes straight to DONE
        start = 1'b1; cfg_len = '0;
        @(negedge clk);
        start = 1'b0;
        chk("zlen_valid", res_valid, 1);
        chk("zlen_data", res_data, 0);
        chk("zlen_clr_n", mac_clr_n, 1);
        chk("zlen_ready", in_ready, 0);
        chk("zlen_count", res_count, 0);
        @(negedge clk);
        chk("zlen_ready2", in_ready, 0);
        chk("zlen_clr_n2", mac_clr_n, 1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("zlen_idle", busy, 0);

        // T5: result held 5 cycles while start is pulsed; start ignored
        ia[0] = 3; ib[0] = 2; bub[0] = 0;
        ia[1] = 4; ib[1] = 0; bub[1] = 1;
        run_job(2, 5, 1);

        // T6: abort after 1 of 4 accepts, then a fresh job must see a clean accumulator
        ia[0] = 3; ib[0] = 3; bub[0] = 0;
        start_job(4);
        feed_pair(0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_mac_a", mac_a, 0);
        chk("abort_ready", in_ready, 0);
        chk("abort_clr_n", mac_clr_n, 1);
        chk("abort_valid", res_valid, 0);
        ia[0] = 3; ib[0] = 1; bub[0] = 0;
        run_job(1, 0, 0);

        // Abort during DRAIN: no result ever appears
        ia[0] = 1; ib[0] = 1; bub[0] = 0;
        start_job(1);
        feed_pair(0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("drain_abort_valid", res_valid, 0);
        end

        // Async reset mid-FEED clears registers immediately
        ia[0] = 2; ib[0] = 2; bub[0] = 0;
        start_job(3);
        feed_pair(0);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_mac_a", mac_a, 0);
        chk("arst_clr_n", mac_clr_n, 1);
        chk("arst_count", res_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized jobs
        for (int j = 0; j < 10; j++) begin
            int len;
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                ia[i]  = ($urandom_range(0, 15) == 0) ? 5 : int'($urandom_range(0, 4));
                ib[i]  = ($urandom_range(0, 15) == 0) ? 5 : int'($urandom_range(0, 4));
                bub[i] = int'($urandom_range(0, 2));
            end
            run_job(len, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
